// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl: data-bus controller behind the buffer register.
// Collects serial store data, runs one classic Wishbone transaction per
// i_start, then aligns, extends and streams load data back serially.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_en                          serial step enable (store shift-in, load shift-out)
//   i_start, i_we, i_size,
//   i_signed, i_lsb, i_adr        transaction request, sampled on i_start
//   i_rs2                         serial store data, LS chunk first
//   o_rd                          serial load result, LS chunk first (zero when !i_en)
//   o_busy, o_done, o_misalign    status; done/misalign are one-cycle pulses
//   o_dbus_*                      bus request (adr, dat, sel, we, cyc)
//   i_dbus_rdt, i_dbus_ack        bus response
module serv_dbus_ctrl #(
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_start,
  input  logic                      i_we,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_adr,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_misalign,
  output logic [31:0]               o_dbus_adr,
  output logic [31:0]               o_dbus_dat,
  output logic [3:0]                o_dbus_sel,
  output logic                      o_dbus_we,
  output logic                      o_dbus_cyc,
  input  logic [31:0]               i_dbus_rdt,
  input  logic                      i_dbus_ack
);

  localparam int unsigned LB    = $clog2(BITS_PER_CYCLE);
  localparam int unsigned STEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_nxt;
  logic        launch, capture, done_nxt, misalign_nxt, misaligned;

  logic [31:0] adr, dat, wdat, rdat;
  logic [3:0]  sel;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [1:0]  lsb;
  logic        sign_bit;
  logic [CW-1:0] cnt;
  logic        wrapped;
  logic        done, misalign;

  logic [31:0] dat_c;
  logic [3:0]  sel_c;
  logic [31:0] rdt_shift;
  logic        rdt_sign;
  logic [5:0]  pos;
  logic        in_width;
  logic        fill;
  logic [BITS_PER_CYCLE-1:0] chunk;

  // Access rule: halves need lsb[0]==0, words (incl. size 11) need lsb==00
  assign misaligned = ((i_size == 2'b01) && i_lsb[0]) ||
                      (i_size[1] && (i_lsb != 2'b00));

  // Write-data replication and byte enables for the requested access
  always_comb begin
    dat_c = wdat;
    sel_c = 4'b1111;
    case (i_size)
      2'b00: begin
        dat_c = {4{wdat[7:0]}};
        sel_c = 4'(4'b0001 << i_lsb);
      end
      2'b01: begin
        dat_c = {2{wdat[15:0]}};
        sel_c = 4'(4'b0011 << i_lsb);
      end
      default: begin
        dat_c = wdat;
        sel_c = 4'b1111;
      end
    endcase
  end

  // Load alignment: bring the addressed byte/half down to bit 0
  assign rdt_shift = i_dbus_rdt >> {lsb, 3'b000};

  always_comb begin
    rdt_sign = rdt_shift[31];
    case (size)
      2'b00:   rdt_sign = rdt_shift[7];
      2'b01:   rdt_sign = rdt_shift[15];
      default: rdt_sign = rdt_shift[31];
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and control strobes
  always_comb begin
    state_nxt    = state;
    launch       = 1'b0;
    capture      = 1'b0;
    done_nxt     = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (misaligned) begin
            misalign_nxt = 1'b1;
          end else begin
            launch    = 1'b1;
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (i_dbus_ack) begin
          done_nxt  = 1'b1;
          capture   = !we;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, store shift register, load shift register and counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr      <= '0;
      dat      <= '0;
      sel      <= '0;
      we       <= 1'b0;
      size     <= '0;
      sgn      <= 1'b0;
      lsb      <= '0;
      wdat     <= '0;
      rdat     <= '0;
      sign_bit <= 1'b0;
      cnt      <= '0;
      wrapped  <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      done     <= done_nxt;
      misalign <= misalign_nxt;
      if (launch) begin
        adr  <= i_adr;
        dat  <= dat_c;
        sel  <= sel_c;
        we   <= i_we;
        size <= i_size;
        sgn  <= i_signed;
        lsb  <= i_lsb;
      end
      // Store data is frozen while the bus holds it
      if (i_en && (state == IDLE))
        wdat <= {i_rs2, wdat[31:BITS_PER_CYCLE]};
      // Ack capture wins over a simultaneous shift-out step
      if (capture) begin
        rdat     <= rdt_shift;
        sign_bit <= rdt_sign;
        cnt      <= '0;
        wrapped  <= 1'b0;
      end else if (i_en) begin
        rdat <= rdat >> BITS_PER_CYCLE;
        cnt  <= cnt + CW'(1);
        if (cnt == CW'(STEPS - 1))
          wrapped <= 1'b1;
      end
    end
  end

  // Chunks past the access width (or after the counter wrapped) carry the fill bit
  assign pos      = 6'(cnt) << LB;
  assign in_width = !wrapped && (size[1] || (pos < (size[0] ? 6'd16 : 6'd8)));
  assign fill     = sgn & sign_bit;
  assign chunk    = in_width ? rdat[BITS_PER_CYCLE-1:0] : {BITS_PER_CYCLE{fill}};

  assign o_rd       = i_en ? chunk : '0;
  assign o_busy     = (state == BUS);
  assign o_dbus_cyc = (state == BUS);
  assign o_done     = done;
  assign o_misalign = misalign;
  assign o_dbus_adr = adr;
  assign o_dbus_dat = dat;
  assign o_dbus_sel = sel;
  assign o_dbus_we  = we;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Bench for serv_dbus_ctrl: a table of directed transactions plus
// hand-written sequences for busy-start, reset mid-transaction, ack/i_en
// collision and frozen store data. Results are reassembled to 32 bits so
// the same expectations hold for any BPC.
module tb_serv_dbus_ctrl #(
  parameter int unsigned BPC = 8
);

  localparam int unsigned STEPS = 32 / BPC;

  logic           clk, rst, en, start, we, sgn, ack;
  logic [1:0]     size, lsb;
  logic [31:0]    adr, rdt;
  logic [BPC-1:0] rs2, rd;
  logic           busy, done, mis, dwe, cyc;
  logic [31:0]    dadr, ddat;
  logic [3:0]     dsel;

  int checks = 0;
  int errors = 0;

  serv_dbus_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start), .i_we(we),
    .i_size(size), .i_signed(sgn), .i_lsb(lsb), .i_adr(adr), .i_rs2(rs2),
    .o_rd(rd), .o_busy(busy), .o_done(done), .o_misalign(mis),
    .o_dbus_adr(dadr), .o_dbus_dat(ddat), .o_dbus_sel(dsel), .o_dbus_we(dwe),
    .o_dbus_cyc(cyc), .i_dbus_rdt(rdt), .i_dbus_ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lsb;
    logic [31:0] adr;
    logic [31:0] rs2;
    logic [31:0] rdt;
    int          delay;
    logic        exp_mis;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic [31:0] exp_rd;
    logic [31:0] exp_fill;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic shift_in(input logic [31:0] w);
    for (int i = 0; i < STEPS; i++) begin
      @(negedge clk);
      en  = 1'b1;
      rs2 = w[i*BPC +: BPC];
    end
    @(negedge clk);
    en  = 1'b0;
    rs2 = '0;
  endtask

  // Leaves the bench at the negedge of the first cycle after the start edge
  task automatic do_start(input logic w, input logic [1:0] s, input logic sg,
                          input logic [1:0] l, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; we = w; size = s; sgn = sg; lsb = l; adr = a;
    @(negedge clk);
    start = 1'b0; we = 1'b0; size = '0; sgn = 1'b0; lsb = '0; adr = '0;
  endtask

  // cyc is checked in delay+1 cycles, ack given in the last one
  task automatic bus_phase(input string name, input int delay, input logic [31:0] r);
    for (int d = 0; d < delay; d++) begin
      chk({name, " cyc held"}, 64'(cyc), 64'd1);
      @(negedge clk);
    end
    chk({name, " cyc at ack"}, 64'(cyc), 64'd1);
    ack = 1'b1;
    rdt = r;
    @(negedge clk);
    ack = 1'b0;
    rdt = '0;
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " cyc drop"}, 64'({cyc, busy}), 64'd0);
    @(negedge clk);
    chk({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  task automatic read_out(output logic [63:0] acc);
    acc = '0;
    for (int k = 0; k < 2 * STEPS; k++) begin
      @(negedge clk);
      en = 1'b1;
      #1;
      acc[k*BPC +: BPC] = rd;
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] acc;
    if (v.we) shift_in(v.rs2);
    do_start(v.we, v.size, v.sgn, v.lsb, v.adr);
    chk({v.name, " misalign"}, 64'(mis), 64'(v.exp_mis));
    if (v.exp_mis) begin
      chk({v.name, " no cyc"}, 64'({cyc, busy}), 64'd0);
      @(negedge clk);
      chk({v.name, " misalign pulse"}, 64'(mis), 64'd0);
      chk({v.name, " no done"}, 64'({done, cyc}), 64'd0);
    end else begin
      chk({v.name, " busy"}, 64'(busy), 64'd1);
      chk({v.name, " adr"}, 64'(dadr), 64'(v.adr));
      chk({v.name, " sel"}, 64'(dsel), 64'(v.exp_sel));
      chk({v.name, " we"}, 64'(dwe), 64'(v.we));
      if (v.we) chk({v.name, " dat"}, 64'(ddat), 64'(v.exp_dat));
      bus_phase(v.name, v.delay, v.rdt);
      if (!v.we) begin
        read_out(acc);
        chk({v.name, " rd"}, 64'(acc[31:0]), 64'(v.exp_rd));
        chk({v.name, " fill after wrap"}, 64'(acc[63:32]), 64'(v.exp_fill));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] acc;
    int          n_done;

    //          name        we  sz    sg  lsb    adr           rs2           rdt         dly mis sel      dat           rd            fill
    vecs[0]  = '{"lb_s3",   0, 2'b00, 1, 2'd3, 32'h0000_1000, 32'h0,        32'h80AABBCC, 2, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 32'hFFFFFFFF};
    vecs[1]  = '{"lhu_2",   0, 2'b01, 0, 2'd2, 32'h0000_2004, 32'h0,        32'hF1230000, 0, 0, 4'b1100, 32'h0,        32'h0000F123, 32'h0};
    vecs[2]  = '{"sh_2",    1, 2'b01, 0, 2'd2, 32'h0000_3008, 32'h00001234, 32'h0,        4, 0, 4'b1100, 32'h12341234, 32'h0,        32'h0};
    vecs[3]  = '{"lw_mis",  0, 2'b10, 0, 2'd1, 32'h0000_400C, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[4]  = '{"lh_s2",   0, 2'b01, 1, 2'd2, 32'h0000_5010, 32'h0,        32'h80017FFF, 1, 0, 4'b1100, 32'h0,        32'hFFFF8001, 32'hFFFFFFFF};
    vecs[5]  = '{"lbu_1",   0, 2'b00, 0, 2'd1, 32'h0000_6014, 32'h0,        32'h12345678, 0, 0, 4'b0010, 32'h0,        32'h00000056, 32'h0};
    vecs[6]  = '{"sb_1",    1, 2'b00, 0, 2'd1, 32'h0000_7018, 32'hDEADBEEF, 32'h0,        0, 0, 4'b0010, 32'hEFEFEFEF, 32'h0,        32'h0};
    vecs[7]  = '{"sw_0",    1, 2'b10, 0, 2'd0, 32'h0000_801C, 32'hCAFEF00D, 32'h0,        3, 0, 4'b1111, 32'hCAFEF00D, 32'h0,        32'h0};
    vecs[8]  = '{"lw_sz11", 0, 2'b11, 0, 2'd0, 32'h0000_9020, 32'h0,        32'h89ABCDEF, 1, 0, 4'b1111, 32'h0,        32'h89ABCDEF, 32'h0};
    vecs[9]  = '{"lh_mis",  0, 2'b01, 1, 2'd1, 32'h0000_A024, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{"lb_s0p",  0, 2'b00, 1, 2'd0, 32'h0000_B028, 32'h0,        32'h0000007F, 0, 0, 4'b0001, 32'h0,        32'h0000007F, 32'h0};

    rst = 1'b1; en = 1'b0; start = 1'b0; we = 1'b0; sgn = 1'b0; ack = 1'b0;
    size = '0; lsb = '0; adr = '0; rdt = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset ctl", 64'({busy, done, mis, dwe, cyc}), 64'd0);
    chk("reset adr", 64'(dadr), 64'd0);
    chk("reset dat", 64'(ddat), 64'd0);
    chk("reset sel", 64'(dsel), 64'd0);
    chk("reset rd",  64'(rd), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // i_start while busy is ignored; stray ack in IDLE is ignored
    do_start(1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_C000);
    start = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h0000_D000;
    @(negedge clk);
    start = 1'b0; we = 1'b0; size = '0; adr = '0;
    chk("busy start adr", 64'(dadr), 64'h0000_C000);
    chk("busy start we",  64'(dwe), 64'd0);
    chk("busy start sel", 64'(dsel), 64'b0001);
    bus_phase("busy start", 1, 32'h0000_00AA);
    n_done = 0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (done) n_done++;
      if (cyc) n_done++;
      @(negedge clk);
    end
    chk("stray ack", 64'(n_done), 64'd0);

    // Reset inside a bus cycle; later ack ignored
    do_start(1'b0, 2'b10, 1'b0, 2'd0, 32'h0000_E000);
    chk("rst mid cyc", 64'(cyc), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid drop", 64'({cyc, busy}), 64'd0);
    chk("rst mid adr", 64'(dadr), 64'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("rst late ack", 64'({done, cyc, busy}), 64'd0);
    @(negedge clk);
    chk("rst late ack2", 64'({done, cyc}), 64'd0);

    // i_en coinciding with ack: capture wins, readout starts at chunk 0
    do_start(1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_F000);
    ack = 1'b1; rdt = 32'h1234_56A5; en = 1'b1;
    @(negedge clk);
    ack = 1'b0; rdt = '0; en = 1'b0;
    chk("en+ack done", 64'(done), 64'd1);
    read_out(acc);
    chk("en+ack rd", 64'(acc), 64'h0000_0000_0000_00A5);

    // i_en while busy does not disturb the collected store data
    shift_in(32'h1122_3344);
    do_start(1'b1, 2'b10, 1'b0, 2'd0, 32'h0001_0000);
    chk("frozen dat", 64'(ddat), 64'h1122_3344);
    en = 1'b1; rs2 = '1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0; rs2 = '0;
    bus_phase("frozen", 0, 32'h0);
    do_start(1'b1, 2'b10, 1'b0, 2'd0, 32'h0001_0004);
    chk("frozen dat2", 64'(ddat), 64'h1122_3344);
    bus_phase("frozen2", 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
